point_display_queue: RTL and testbench

POINT_DISPLAY_QUEUE -- requirements
Module: point_display_queue

---
 rtl/point_display_queue.sv | 177 +++++++++++++++++
 tb/tb_point_display_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/point_display_queue.sv
// point_display_queue
//   Buffers points from the triangle stage in a small FIFO and shows them one
//   at a time on four hex/BCD digits. Each point stays on display for HOLD
//   clock cycles. A two-digit BCD counter tracks how many points have been shown.
//
// Handshake: po is a push-only strobe with no ready signal. A point is accepted
//   when the FIFO is not full, or when it is full and the display pops the head
//   in the same cycle. Any other po cycle drops the point and sets the sticky
//   overflow flag.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   reset      asynchronous, active-high
//   po         point-valid strobe; one point per high cycle
//   xo, yo     3-bit point coordinates, valid while po=1
//   dig_a      displayed x as {1'b0,x}; 4'hF when nothing is shown
//   dig_b      displayed y as {1'b0,y}; 4'hF when nothing is shown
//   dig_c      BCD tens of the shown-points count
//   dig_d      BCD units of the shown-points count
//   full       FIFO holds DEPTH entries
//   overflow   sticky: at least one point was dropped since reset
//   fsm_state  debug view of the display FSM (0=IDLE, 1=LOAD, 2=SHOW)
module point_display_queue #(
  parameter int DEPTH = 16,
  parameter int HOLD  = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  output logic [3:0] dig_a,
  output logic [3:0] dig_b,
  output logic [3:0] dig_c,
  output logic [3:0] dig_d,
  output logic       full,
  output logic       overflow,
  output logic [1:0] fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t state, next_state;

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    disp_x, disp_y;
  logic [3:0]    tens, units;

  logic pop;
  logic wr;

  // The FSM only enters LOAD with a non-empty FIFO, so LOAD always pops.
  assign pop  = (state == LOAD);
  assign full = (count == DEPTH_C);
  assign wr   = po && (!full || pop);

  // ---------------------------------------------------------------------------
  // FIFO storage: data is not reset, only the pointers and count are.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= {xo, yo};
    end
  end

  // Pointers are exactly AW bits wide and DEPTH is a power of two, so the
  // increments wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (po && !wr) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // IDLE also looks at po so a point arriving at an empty FIFO reaches the
  // digits two cycles after the strobe. At the end of SHOW only the registered
  // count is used: a write landing in that same cycle waits for the next pass.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if ((count != '0) || po) begin
          next_state = LOAD;
        end
      end
      LOAD: next_state = SHOW;
      SHOW: begin
        if (hold_cnt == '0) begin
          next_state = (count != '0) ? LOAD : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Hold counter, display register and shown counter all update on LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      disp_x   <= '0;
      disp_y   <= '0;
      tens     <= '0;
      units    <= '0;
    end else begin
      if (state == LOAD) begin
        hold_cnt <= HOLD_LAST;
        disp_x   <= mem[rd_ptr][5:3];
        disp_y   <= mem[rd_ptr][2:0];
        if (units == 4'd9) begin
          units <= 4'd0;
          tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
          units <= units + 4'd1;
        end
      end else if ((state == SHOW) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // The point is visible only while in SHOW, which gives exactly HOLD cycles
  // per point and a blank LOAD cycle between consecutive points.
  always_comb begin
    dig_a = 4'hF;
    dig_b = 4'hF;
    if (state == SHOW) begin
      dig_a = {1'b0, disp_x};
      dig_b = {1'b0, disp_y};
    end
  end

  assign dig_c     = tens;
  assign dig_d     = units;
  assign fsm_state = state;

endmodule

// File: tb/tb_point_display_queue.sv
// Directed testbench for point_display_queue with DEPTH=4, HOLD=4.
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, so each check sees the state produced by the edge just passed.
module tb_point_display_queue;

  logic       clk;
  logic       reset;
  logic       po;
  logic [2:0] xo, yo;
  logic [3:0] dig_a, dig_b, dig_c, dig_d;
  logic       full, overflow;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;

  point_display_queue #(.DEPTH(4), .HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .po        (po),
    .xo        (xo),
    .yo        (yo),
    .dig_a     (dig_a),
    .dig_b     (dig_b),
    .dig_c     (dig_c),
    .dig_d     (dig_d),
    .full      (full),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    po    = 1'b0;
    xo    = '0;
    yo    = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic push(input logic [2:0] x, input logic [2:0] y);
    po = 1'b1;
    xo = x;
    yo = y;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Checkers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares all four digits at once as {a,b,c,d}.
  task automatic see(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] d);
    chk(tag, {dig_a, dig_b, dig_c, dig_d}, {a, b, c, d});
  endtask

  // Checks n consecutive cycles of point (x,y) on display, ticking after each.
  task automatic expect_span(input string tag, input logic [2:0] x, input logic [2:0] y,
                             input logic [3:0] c, input logic [3:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      see(tag, {1'b0, x}, {1'b0, y}, c, d);
      tick();
    end
  endtask

  logic [2:0] px [6];
  logic [2:0] py [6];

  initial begin
    reset = 1'b1;
    po    = 1'b0;
    xo    = '0;
    yo    = '0;
    px[0] = 3'd1; py[0] = 3'd1;
    px[1] = 3'd2; py[1] = 3'd3;
    px[2] = 3'd3; py[2] = 3'd5;
    px[3] = 3'd4; py[3] = 3'd7;
    px[4] = 3'd5; py[4] = 3'd2;
    px[5] = 3'd6; py[5] = 3'd6;

    // ---- reset state ----
    do_reset();
    see("rst_digits", 4'hF, 4'hF, 4'h0, 4'h0);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_state", 16'(fsm_state), 16'd0);

    // ---- single point (3,5) ----
    push(3'd3, 3'd5);
    po = 1'b0;
    chk("single_load_state", 16'(fsm_state), 16'd1);
    see("single_load_blank", 4'hF, 4'hF, 4'h0, 4'h0);
    tick();
    expect_span("single_show", 3'd3, 3'd5, 4'h0, 4'h1, 4);
    see("single_after_blank", 4'hF, 4'hF, 4'h0, 4'h1);
    chk("single_idle_state", 16'(fsm_state), 16'd0);

    // ---- burst of 3 ----
    do_reset();
    push(3'd1, 3'd2);
    push(3'd4, 3'd4);
    push(3'd7, 3'd0);
    po = 1'b0;
    expect_span("burst_p0", 3'd1, 3'd2, 4'h0, 4'h1, 3);
    see("burst_gap0", 4'hF, 4'hF, 4'h0, 4'h1);
    tick();
    expect_span("burst_p1", 3'd4, 3'd4, 4'h0, 4'h2, 4);
    see("burst_gap1", 4'hF, 4'hF, 4'h0, 4'h2);
    tick();
    expect_span("burst_p2", 3'd7, 3'd0, 4'h0, 4'h3, 4);
    see("burst_end", 4'hF, 4'hF, 4'h0, 4'h3);
    chk("burst_ovf", 16'(overflow), 16'd0);

    // ---- overflow: 6 back-to-back, 6th dropped ----
    do_reset();
    push(px[0], py[0]);
    push(px[1], py[1]);
    see("ovf_p0_first", {1'b0, px[0]}, {1'b0, py[0]}, 4'h0, 4'h1);
    push(px[2], py[2]);
    push(px[3], py[3]);
    chk("ovf_not_full_yet", 16'(full), 16'd0);
    push(px[4], py[4]);
    chk("ovf_full_after5", 16'(full), 16'd1);
    chk("ovf_clear_after5", 16'(overflow), 16'd0);
    push(px[5], py[5]);
    po = 1'b0;
    chk("ovf_set", 16'(overflow), 16'd1);
    chk("ovf_full_still", 16'(full), 16'd1);
    see("ovf_load_blank", 4'hF, 4'hF, 4'h0, 4'h1);
    for (int k = 1; k < 5; k++) begin
      tick();
      expect_span("ovf_show", px[k], py[k], 4'h0, 4'(k + 1), 4);
      see("ovf_gap", 4'hF, 4'hF, 4'h0, 4'(k + 1));
    end
    chk("ovf_idle_state", 16'(fsm_state), 16'd0);
    chk("ovf_sticky", 16'(overflow), 16'd1);
    chk("ovf_drained", 16'(full), 16'd0);

    // ---- full plus pop in LOAD ----
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(3'(7 - k), 3'(k));
    end
    po = 1'b0;
    chk("fp_full", 16'(full), 16'd1);
    tick();
    chk("fp_load_state", 16'(fsm_state), 16'd1);
    chk("fp_full_in_load", 16'(full), 16'd1);
    push(3'd0, 3'd7);
    po = 1'b0;
    chk("fp_full_kept", 16'(full), 16'd1);
    chk("fp_no_ovf", 16'(overflow), 16'd0);
    expect_span("fp_show", 3'd6, 3'd1, 4'h0, 4'h2, 4);
    see("fp_gap", 4'hF, 4'hF, 4'h0, 4'h2);
    for (int k = 2; k < 6; k++) begin
      tick();
      if (k < 5) begin
        expect_span("fp_show", 3'(7 - k), 3'(k), 4'h0, 4'(k + 1), 4);
      end else begin
        expect_span("fp_last", 3'd0, 3'd7, 4'h0, 4'h6, 4);
      end
      see("fp_gap", 4'hF, 4'hF, 4'h0, 4'(k + 1));
    end
    chk("fp_ovf_end", 16'(overflow), 16'd0);

    // ---- reset during SHOW with 2 points queued ----
    do_reset();
    push(3'd1, 3'd6);
    push(3'd2, 3'd5);
    push(3'd3, 3'd4);
    po = 1'b0;
    see("rs_pre_show", 4'h1, 4'h6, 4'h0, 4'h1);
    #2;
    reset = 1'b1;
    #1;
    see("rs_async_digits", 4'hF, 4'hF, 4'h0, 4'h0);
    chk("rs_async_state", 16'(fsm_state), 16'd0);
    chk("rs_async_full", 16'(full), 16'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    see("rs_stay_blank", 4'hF, 4'hF, 4'h0, 4'h0);
    chk("rs_stay_idle", 16'(fsm_state), 16'd0);
    push(3'd5, 3'd1);
    po = 1'b0;
    tick();
    see("rs_new_point", 4'h5, 4'h1, 4'h0, 4'h1);

    // ---- BCD wrap over 100 points ----
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      push(3'(i), 3'(i + 3));
      po = 1'b0;
      repeat (5) tick();
      if (i == 10) see("bcd_10", 4'hF, 4'hF, 4'h1, 4'h0);
      if (i == 99) see("bcd_99", 4'hF, 4'hF, 4'h9, 4'h9);
      if (i == 100) see("bcd_100", 4'hF, 4'hF, 4'h0, 4'h0);
    end
    chk("bcd_no_ovf", 16'(overflow), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
